pc_gen: RTL

//  Parametrised fetch-PC generator for the pipeline front end.
//  - Produces the fetch address each cycle with a valid/ready handshake to instruction memory.
//  - Arbitrates trap, branch/jump redirect and stall.
//  - Buffers a redirect that arrives while fetch is blocked, so no redirect is ever lost.
//  - Sits between EX/trap logic and the IF stage.

---
 rtl/pc_pkg.sv | 15 +
 rtl/pc_ras.sv | 52 +++++
 rtl/pc_gen.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared types for the fetch-PC generator: FSM states, next-PC select codes
// and the STEP alignment mask helper.
package pc_pkg;

   typedef enum logic [1:0] {BOOT, RUN, HOLD} pc_state_e;

   typedef enum logic [2:0] {
      SEL_TRAP, SEL_REDIR, SEL_PEND, SEL_RAS, SEL_SEQ, SEL_HOLD
   } pc_sel_e;

   function automatic int unsigned align_mask(input int unsigned step);
      return step - 1;
   endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push on full overwrites the oldest entry,
// push+pop in one cycle replaces the top in place.
module pc_ras #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  logic [XLEN-1:0] push_dat,
   output logic [XLEN-1:0] top,
   output logic            empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [XLEN-1:0] mem [DEPTH];
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   ptr_m1;
   logic [PW:0]     count;

   assign ptr_m1 = ptr - 1'b1;
   assign top    = mem[ptr_m1];
   assign empty  = (count == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr   <= '0;
         count <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               ptr <= ptr + 1'b1;
               if (count != FULL) count <= count + 1'b1;
            end
            2'b01: begin
               ptr   <= ptr_m1;
               count <= count - 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Storage needs no reset: count guards every read.
   always_ff @(posedge clk) begin
      if (push) mem[pop ? ptr_m1 : ptr] <= push_dat;
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator: trap > redirect > pending redirect > RAS > sequential.
// Optional return-address stack enabled with macro PC_RAS_EN.
module pc_gen
   import pc_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter int              STEP      = 4,
   parameter int              RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect_vld,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            trap_vld,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            fetch_rdy,
`ifdef PC_RAS_EN
   input  logic            ras_push,
   input  logic            ras_pop,
`endif
   output logic            fetch_vld,
   output logic [XLEN-1:0] fetch_pc,
   output logic            misalign
);

   localparam logic [XLEN-1:0] STEP_W = XLEN'(STEP);
   localparam logic [XLEN-1:0] MASK   = XLEN'(align_mask(STEP));

   pc_state_e       state, state_nxt;
   pc_sel_e         sel;
   logic [XLEN-1:0] pc, pc_nxt;
   logic [XLEN-1:0] pend_pc;
   logic            pend_vld;
   logic            squash;
   logic            advance;
   logic            blocked;
   logic            ras_hit;
   logic [XLEN-1:0] ras_top;

   // A squashed (invalid) request must not count as accepted.
   assign advance  = fetch_vld & fetch_rdy & ~stall;
   assign blocked  = (state != BOOT) & ~advance;
   assign fetch_pc = pc;

`ifdef PC_RAS_EN
   logic ras_empty;
   assign ras_hit = ras_pop & ~ras_empty;

   pc_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
      .clk      (clk),
      .rst      (rst),
      .push     (ras_push),
      .pop      (sel == SEL_RAS),
      .push_dat (pc + STEP_W),
      .top      (ras_top),
      .empty    (ras_empty)
   );
`else
   assign ras_hit = 1'b0;
   assign ras_top = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= BOOT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         BOOT: state_nxt = RUN;
         RUN, HOLD: begin
            if (trap_vld)                    state_nxt = RUN;
            else if (redirect_vld)           state_nxt = advance ? RUN : HOLD;
            else if (state == HOLD && advance) state_nxt = RUN;
         end
         default: state_nxt = BOOT;
      endcase
   end

   always_comb begin
      fetch_vld = (state != BOOT) & ~squash;
   end

   always_comb begin
      sel = SEL_HOLD;
      if (trap_vld)              sel = SEL_TRAP;
      else if (redirect_vld)     sel = SEL_REDIR;
      else if (pend_vld)         sel = advance ? SEL_PEND : SEL_HOLD;
      else if (advance & ras_hit) sel = SEL_RAS;
      else if (advance)          sel = SEL_SEQ;
   end

   // pc already equals pend_pc while held; acceptance moves past it.
   always_comb begin
      case (sel)
         SEL_TRAP:  pc_nxt = trap_pc;
         SEL_REDIR: pc_nxt = redirect_pc;
         SEL_PEND:  pc_nxt = pend_pc + STEP_W;
         SEL_RAS:   pc_nxt = ras_top;
         SEL_SEQ:   pc_nxt = pc + STEP_W;
         default:   pc_nxt = pc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_VEC;
         pend_vld <= 1'b0;
         pend_pc  <= '0;
         squash   <= 1'b0;
         misalign <= 1'b0;
      end else begin
         pc       <= pc_nxt;
         squash   <= (trap_vld | redirect_vld) & blocked;
         misalign <= (sel == SEL_TRAP || sel == SEL_REDIR || sel == SEL_RAS)
                     && ((pc_nxt & MASK) != '0);
         if (trap_vld) begin
            pend_vld <= 1'b0;
         end else if (redirect_vld) begin
            pend_vld <= blocked;
            pend_pc  <= redirect_pc;
         end else if (pend_vld && advance) begin
            pend_vld <= 1'b0;
         end
      end
   end

endmodule
